array_extrema_engine: RTL and testbench

- Multi-cycle scan engine that streams a contiguous array out of a synchronous-read data memory and reports its extreme value and that value's index.
- Parametrised successor of the fixed 16-bit max-finder processor: configurable data/address width, runtime max/min and signed/unsigned mode, runtime base/length, and a start/done handshake.
- Sits beside the data memory as a coprocessor; it is sequenced by the top level or a controller.

---
 rtl/array_extrema_engine.sv | 121 ++++++++++++
 tb/tb_array_extrema_engine.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/array_extrema_engine.sv
// Scans mem[base .. base+length-1] through a one-deep compare stage and reports the max/min value and its offset.
// Optional feature macro EXTREMA_DUAL_EN: also tracks the opposite extreme in the same pass.
module array_extrema_engine #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  localparam int LEN_W = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_min,
  input  logic              mode_signed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              empty,
  output logic [DATA_W-1:0] result,
  output logic [LEN_W-1:0]  result_index
`ifdef EXTREMA_DUAL_EN
  ,
  output logic [DATA_W-1:0] result_alt,
  output logic [LEN_W-1:0]  result_alt_index
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  cnt, len_q, idx_q;
  logic [ADDR_W-1:0] base_q;
  logic              min_q, sgn_q, rd_q;
  logic              fetch_last, win;

  function automatic logic less_than(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                     input logic sgn);
    return sgn ? ($signed(a) < $signed(b)) : (a < b);
  endfunction

  assign fetch_last = (cnt == len_q - LEN_W'(1));
  assign win = min_q ? less_than(mem_rdata, result, sgn_q) : less_than(result, mem_rdata, sgn_q);

  assign busy     = (state == FETCH) || (state == DRAIN);
  assign done     = (state == FINISH);
  assign mem_rd   = (state == FETCH);
  assign mem_addr = mem_rd ? base_q + cnt[ADDR_W-1:0] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length == '0) ? FINISH : FETCH;
      FETCH:   if (fetch_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef EXTREMA_DUAL_EN
  logic win_alt;
  assign win_alt = min_q ? less_than(result_alt, mem_rdata, sgn_q)
                         : less_than(mem_rdata, result_alt, sgn_q);
`endif

  always_ff @(posedge clock) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      base_q       <= '0;
      min_q        <= 1'b0;
      sgn_q        <= 1'b0;
      rd_q         <= 1'b0;
      empty        <= 1'b0;
      result       <= '0;
      result_index <= '0;
`ifdef EXTREMA_DUAL_EN
      result_alt       <= '0;
      result_alt_index <= '0;
`endif
    end else begin
      state <= state_nxt;
      // Data returns one cycle after the read, so the issue offset is delayed alongside it.
      rd_q  <= mem_rd;
      idx_q <= cnt;
      if (state == IDLE && start) begin
        base_q       <= base_addr;
        len_q        <= length;
        min_q        <= mode_min;
        sgn_q        <= mode_signed;
        cnt          <= '0;
        empty        <= (length == '0);
        result       <= '0;
        result_index <= '0;
`ifdef EXTREMA_DUAL_EN
        result_alt       <= '0;
        result_alt_index <= '0;
`endif
      end else if (state == FETCH) begin
        cnt <= cnt + LEN_W'(1);
      end
      if (rd_q) begin
        if (idx_q == '0 || win) begin
          result       <= mem_rdata;
          result_index <= idx_q;
        end
`ifdef EXTREMA_DUAL_EN
        if (idx_q == '0 || win_alt) begin
          result_alt       <= mem_rdata;
          result_alt_index <= idx_q;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_array_extrema_engine.sv
// Directed and randomized scans of array_extrema_engine against an array-level reference model.
module tb_array_extrema_engine;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int LW = 11;
  localparam int MEM_N = 1024;

  logic          clock = 1'b0;
  logic          rst, start, mode_min, mode_signed;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata;
  logic          busy, done, empty;
  logic [DW-1:0] result;
  logic [LW-1:0] result_index;
`ifdef EXTREMA_DUAL_EN
  logic [DW-1:0] result_alt;
  logic [LW-1:0] result_alt_index;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem [0:MEM_N-1];
  int addr_q[$];

  array_extrema_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .rst(rst), .start(start), .mode_min(mode_min), .mode_signed(mode_signed),
    .base_addr(base_addr), .length(length), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .empty(empty), .result(result),
    .result_index(result_index)
`ifdef EXTREMA_DUAL_EN
    , .result_alt(result_alt), .result_alt_index(result_alt_index)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous-read memory: data one cycle after the strobe.
  always @(posedge clock) if (mem_rd === 1'b1) mem_rdata <= mem[mem_addr];

  always @(negedge clock) if (mem_rd === 1'b1) addr_q.push_back(int'(mem_addr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the array, keep the earliest strictly-best element under the chosen ordering.
  task automatic model(input int b, input int n, input bit mn, input bit sg,
                       output logic [DW-1:0] r, output int ri,
                       output logic [DW-1:0] ra, output int rai);
    longint best, best_a, key;
    logic [DW-1:0] v;
    r = '0; ri = 0; ra = '0; rai = 0; best = 0; best_a = 0;
    for (int i = 0; i < n; i++) begin
      v = mem[(b + i) % MEM_N];
      key = sg ? longint'($signed(v)) : longint'(v);
      if (i == 0 || (mn ? key < best : key > best)) begin
        best = key; r = v; ri = i;
      end
      if (i == 0 || (mn ? key > best_a : key < best_a)) begin
        best_a = key; ra = v; rai = i;
      end
    end
  endtask

  task automatic run(input int b, input int n, input bit mn, input bit sg, input bit spam,
                     input string tag);
    logic [DW-1:0] er, ea;
    int ei, eai, cyc, exp_lat;
    bit ok;
    model(b, n, mn, sg, er, ei, ea, eai);
    @(negedge clock);
    addr_q.delete();
    base_addr = AW'(b); length = LW'(n); mode_min = mn; mode_signed = sg; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    base_addr = AW'($urandom); length = LW'($urandom);
    mode_min = 1'($urandom); mode_signed = 1'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 2000) begin
      start = spam && (cyc % 3 == 1);
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    exp_lat = (n == 0) ? 1 : n + 2;
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_index"}, 64'(result_index), 64'(ei));
    chk({tag, "_empty"}, 64'(empty), 64'(n == 0));
`ifdef EXTREMA_DUAL_EN
    chk({tag, "_alt"}, 64'(result_alt), 64'(ea));
    chk({tag, "_alt_index"}, 64'(result_alt_index), 64'(eai));
`endif
    ok = (addr_q.size() == n);
    for (int i = 0; i < addr_q.size() && ok; i++)
      if (addr_q[i] != (b + i) % MEM_N) ok = 1'b0;
    chk({tag, "_addr_seq"}, 64'(ok), 64'(1));
    // A start coinciding with done must be dropped.
    start = 1'b1;
    base_addr = AW'($urandom); length = LW'($urandom_range(1, 20));
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_start_at_done_ignored"}, 64'({busy, done}), 64'(0));
  endtask

  initial begin
    int pulses;
    rst = 1'b0; start = 1'b0; mode_min = 1'b0; mode_signed = 1'b0;
    base_addr = '0; length = '0;
    for (int i = 0; i < MEM_N; i++) mem[i] = DW'($urandom);
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_empty", 64'(empty), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_index", 64'(result_index), 64'(0));
    chk("rst_mem_rd", 64'(mem_rd), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    rst = 1'b1;

    mem[100] = 16'd3; mem[101] = 16'hFFFE; mem[102] = 16'd7;
    mem[103] = 16'hFFFE; mem[104] = 16'd1; mem[105] = 16'd0;
    run(100, 6, 1'b0, 1'b0, 1'b0, "umax");
    chk("umax_const_val", 64'(result), 64'hFFFE);
    chk("umax_const_idx", 64'(result_index), 64'(1));
`ifdef EXTREMA_DUAL_EN
    chk("umax_const_alt", 64'(result_alt), 64'(0));
    chk("umax_const_alt_idx", 64'(result_alt_index), 64'(5));
`endif

    // Abort a scan with reset at cycle 3.
    @(negedge clock);
    base_addr = AW'(200); length = LW'(8); mode_min = 1'b0; mode_signed = 1'b0; start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock); rst = 1'b0;
    @(negedge clock);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_result", 64'(result), 64'(0));
    chk("midrst_index", 64'(result_index), 64'(0));
    chk("midrst_mem_rd", 64'(mem_rd), 64'(0));
    rst = 1'b1;
    pulses = 0;
    repeat (15) begin @(negedge clock); if (done === 1'b1) pulses++; end
    chk("midrst_no_done", 64'(pulses), 64'(0));

    run(100, 6, 1'b1, 1'b1, 1'b1, "smin");
    chk("smin_const_val", 64'(result), 64'hFFFE);
    chk("smin_const_idx", 64'(result_index), 64'(1));
    run(100, 6, 1'b1, 1'b0, 1'b0, "umin");
    chk("umin_const_val", 64'(result), 64'(0));
    chk("umin_const_idx", 64'(result_index), 64'(5));

    mem[1022] = 16'd5; mem[1023] = 16'd9; mem[0] = 16'd9; mem[1] = 16'd2;
    run(1022, 4, 1'b0, 1'b0, 1'b0, "wrap");
    chk("wrap_const_val", 64'(result), 64'(9));
    chk("wrap_const_idx", 64'(result_index), 64'(1));

    run(5, 0, 1'b0, 1'b0, 1'b0, "len0");
    run(7, 1, 1'b1, 1'b1, 1'b0, "len1");

    for (int i = 0; i < MEM_N; i++) mem[i] = DW'($urandom) & 16'h80FF;
    run(int'($urandom_range(0, MEM_N - 1)), MEM_N, 1'b0, 1'b1, 1'b1, "full");

    for (int t = 0; t < 24; t++) begin
      int b, n;
      b = int'($urandom_range(0, MEM_N - 1));
      n = int'($urandom_range(1, 50));
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 2))
          0:       mem[(b + i) % MEM_N] = DW'($urandom_range(0, 3));
          1:       mem[(b + i) % MEM_N] = DW'($urandom) & 16'h8003;
          default: mem[(b + i) % MEM_N] = DW'($urandom);
        endcase
      end
      run(b, n, 1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
